// File: rtl/obf_seqgen_pkg.sv
// obf_seqgen_pkg: shared definitions for the sequential obfuscated-instruction
// generator (obf_seqgen) and its output register (obf_seq_outreg).
//   - default widths for the step index and the key
//   - default maximum sequence length
//   - controller state encoding
package obf_seqgen_pkg;

  localparam int OBF_PPC_WIDTH = 4;
  localparam int OBF_KEY_WIDTH = 8;
  localparam int OBF_MAX_SEQ   = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EMIT   = 2'd1,
    ST_BYPASS = 2'd2
  } obf_state_t;

endpackage

// File: rtl/obf_seq_outreg.sv
// obf_seq_outreg: one-entry output register for the obf_seqgen stream.
// Ports:
//   clk, rst         core clock, asynchronous active-low reset
//   flush            drop the held entry (highest priority)
//   load             capture d_insn/d_last/d_skip and mark valid
//   d_insn/d_last/d_skip  next entry
//   obf_ready        downstream accepts the held entry
//   obf_valid/obf_insn/obf_last/obf_skip  registered stream outputs
// Fields are only written on load, so they stay stable while the entry
// waits for obf_ready.
module obf_seq_outreg
  import obf_seqgen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] d_insn,
  input  logic        d_last,
  input  logic        d_skip,
  input  logic        obf_ready,
  output logic        obf_valid,
  output logic [31:0] obf_insn,
  output logic        obf_last,
  output logic        obf_skip
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      obf_valid <= 1'b0;
      obf_insn  <= '0;
      obf_last  <= 1'b0;
      obf_skip  <= 1'b0;
    end else if (flush) begin
      obf_valid <= 1'b0;
    end else if (load) begin
      obf_valid <= 1'b1;
      obf_insn  <= d_insn;
      obf_last  <= d_last;
      obf_skip  <= d_skip;
    end else if (obf_ready) begin
      obf_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/obf_seqgen.sv
// obf_seqgen: sequential obfuscated-instruction generator controller.
// Accepts one reference instruction, then walks the step index (gen_ppc)
// with a frozen key snapshot (gen_key) through an external combinational
// generator, streaming each generated instruction out over valid/ready.
// Ports:
//   clk, rst                       core clock, asynchronous active-low reset
//   ref_valid/ref_ready/ref_insn   reference instruction input handshake
//   obf_en                         1 = obfuscate, 0 = bypass (sampled at accept)
//   key_i/key_we                   key write port
//   flush                          abort the current sequence
//   gen_ref/gen_ppc/gen_key        drive to the external generator
//   gen_insn/gen_last/gen_skip     generator results
//   obf_valid/obf_ready/obf_insn/obf_last/obf_skip  output stream
//   seq_err                        sticky: a sequence was cut at MAX_SEQ
// Optional build macro OBF_SEQ_STATS_EN adds stat_seq / stat_insn counters.
//
// state  | meaning
// IDLE   | waiting for a reference instruction; key writes apply at once
// EMIT   | stepping gen_ppc, one generated instruction per load
// BYPASS | emitting the reference instruction unchanged as a 1-entry sequence
module obf_seqgen
  import obf_seqgen_pkg::*;
#(
  parameter int PPC_WIDTH = OBF_PPC_WIDTH,
  parameter int KEY_WIDTH = OBF_KEY_WIDTH,
  parameter int MAX_SEQ   = OBF_MAX_SEQ
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ref_valid,
  output logic                 ref_ready,
  input  logic [31:0]          ref_insn,
  input  logic                 obf_en,
  input  logic [KEY_WIDTH-1:0] key_i,
  input  logic                 key_we,
  input  logic                 flush,
  output logic [31:0]          gen_ref,
  output logic [PPC_WIDTH-1:0] gen_ppc,
  output logic [KEY_WIDTH-1:0] gen_key,
  input  logic [31:0]          gen_insn,
  input  logic                 gen_last,
  input  logic                 gen_skip,
  output logic                 obf_valid,
  input  logic                 obf_ready,
  output logic [31:0]          obf_insn,
  output logic                 obf_last,
  output logic                 obf_skip,
  output logic                 seq_err
`ifdef OBF_SEQ_STATS_EN
  ,
  output logic [15:0]          stat_seq,
  output logic [15:0]          stat_insn
`endif
);

  localparam logic [PPC_WIDTH-1:0] PPC_LAST = PPC_WIDTH'(MAX_SEQ - 1);

  obf_state_t           state;
  logic                 alive;
  logic [KEY_WIDTH-1:0] key_reg;
  logic [KEY_WIDTH-1:0] key_pend;
  logic                 key_pend_vld;
  logic [KEY_WIDTH-1:0] key_ret;
  logic                 out_free;
  logic                 load;
  logic                 forced_last;
  logic                 d_last;
  logic                 d_skip;
  logic [31:0]          d_insn;

  // alive keeps ref_ready low until the first clock after reset release.
  assign out_free    = !obf_valid || obf_ready;
  assign ref_ready   = alive && !flush && (state == ST_IDLE) &&
                       (!obf_valid || (obf_ready && obf_last));
  assign load        = !flush && (state != ST_IDLE) && out_free;
  assign forced_last = (state == ST_EMIT) && (gen_ppc == PPC_LAST);
  assign d_last      = (state == ST_BYPASS) || gen_last || forced_last;
  assign d_skip      = (state == ST_EMIT) && gen_skip;
  assign d_insn      = (state == ST_BYPASS) ? gen_ref : gen_insn;

  // Key value to install when (re)entering or sitting in IDLE: a write in
  // this very cycle wins over an older staged value.
  assign key_ret = key_we ? key_i : (key_pend_vld ? key_pend : key_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      alive        <= 1'b0;
      gen_ref      <= '0;
      gen_ppc      <= '0;
      gen_key      <= '0;
      key_reg      <= '0;
      key_pend     <= '0;
      key_pend_vld <= 1'b0;
      seq_err      <= 1'b0;
    end else begin
      alive <= 1'b1;
      if (flush) begin
        state        <= ST_IDLE;
        gen_ppc      <= '0;
        key_reg      <= key_ret;
        key_pend_vld <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            key_reg      <= key_ret;
            key_pend_vld <= 1'b0;
            if (ref_valid && ref_ready) begin
              gen_ref <= ref_insn;
              gen_key <= key_reg;
              gen_ppc <= '0;
              state   <= obf_en ? ST_EMIT : ST_BYPASS;
            end
          end
          ST_EMIT: begin
            if (key_we) begin
              key_pend     <= key_i;
              key_pend_vld <= 1'b1;
            end
            if (load) begin
              if (d_last) begin
                state        <= ST_IDLE;
                gen_ppc      <= '0;
                key_reg      <= key_ret;
                key_pend_vld <= 1'b0;
                if (!gen_last) seq_err <= 1'b1;
              end else begin
                gen_ppc <= gen_ppc + 1'b1;
              end
            end
          end
          ST_BYPASS: begin
            if (key_we) begin
              key_pend     <= key_i;
              key_pend_vld <= 1'b1;
            end
            if (load) begin
              state        <= ST_IDLE;
              key_reg      <= key_ret;
              key_pend_vld <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  obf_seq_outreg u_outreg (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .load      (load),
    .d_insn    (d_insn),
    .d_last    (d_last),
    .d_skip    (d_skip),
    .obf_ready (obf_ready),
    .obf_valid (obf_valid),
    .obf_insn  (obf_insn),
    .obf_last  (obf_last),
    .obf_skip  (obf_skip)
  );

`ifdef OBF_SEQ_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_seq  <= '0;
      stat_insn <= '0;
    end else if (obf_valid && obf_ready) begin
      if (stat_insn != 16'hFFFF) stat_insn <= stat_insn + 16'd1;
      if (obf_last && (stat_seq != 16'hFFFF)) stat_seq <= stat_seq + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_obf_seqgen.sv
module tb_obf_seqgen;

  localparam int MAX_SEQ = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ref_valid, ref_ready, obf_en, key_we, flush;
  logic [31:0] ref_insn;
  logic [7:0]  key_i;
  logic [31:0] gen_ref;
  logic [3:0]  gen_ppc;
  logic [7:0]  gen_key;
  logic [31:0] gen_insn;
  logic        gen_last, gen_skip;
  logic        obf_valid, obf_ready, obf_last, obf_skip, seq_err;
  logic [31:0] obf_insn;
`ifdef OBF_SEQ_STATS_EN
  logic [15:0] stat_seq, stat_insn;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int len_override = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  obf_seqgen dut (
    .clk(clk), .rst(rst),
    .ref_valid(ref_valid), .ref_ready(ref_ready), .ref_insn(ref_insn),
    .obf_en(obf_en), .key_i(key_i), .key_we(key_we), .flush(flush),
    .gen_ref(gen_ref), .gen_ppc(gen_ppc), .gen_key(gen_key),
    .gen_insn(gen_insn), .gen_last(gen_last), .gen_skip(gen_skip),
    .obf_valid(obf_valid), .obf_ready(obf_ready), .obf_insn(obf_insn),
    .obf_last(obf_last), .obf_skip(obf_skip), .seq_err(seq_err)
`ifdef OBF_SEQ_STATS_EN
    ,
    .stat_seq(stat_seq), .stat_insn(stat_insn)
`endif
  );

  // External generator stand-in: sequence length comes from the reference
  // instruction (or a directed override).
  function automatic int seq_len(input logic [31:0] r, input int ovr);
    if (ovr != 0) return ovr;
    return int'(r[7:4]) % 10 + 1;
  endfunction

  assign gen_insn = gen_ref ^ {gen_key, 20'h0, gen_ppc};
  assign gen_skip = gen_ppc[0] ^ gen_ref[4];
  assign gen_last = (int'(gen_ppc) == seq_len(gen_ref, len_override) - 1);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: every accepted instruction expands into a queue of the
  // instructions that must come out, in order.
  typedef struct {
    logic [31:0] insn;
    logic        last;
    logic        skip;
    logic        forced;
  } item_t;

  item_t q[$];
  logic [7:0] key_model = 8'h00;
  bit  err_model = 1'b0;
  int  n_deliv = 0;
  int  m_seq = 0, m_insn = 0;
  item_t it;
  logic  exp_rr;

  always @(negedge clk) begin
    if (mon_en) begin
      exp_rr = !flush && (q.size() == 0 ||
               (q.size() == 1 && q[0].last && obf_valid && obf_ready));
      chk("ref_ready", {31'h0, ref_ready}, {31'h0, exp_rr});
`ifdef OBF_SEQ_STATS_EN
      chk("stat_insn", {16'h0, stat_insn}, m_insn);
      chk("stat_seq", {16'h0, stat_seq}, m_seq);
`endif
      if (obf_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", {31'h0, obf_valid}, 32'h0);
        end else begin
          chk("obf_insn", obf_insn, q[0].insn);
          chk("obf_last", {31'h0, obf_last}, {31'h0, q[0].last});
          chk("obf_skip", {31'h0, obf_skip}, {31'h0, q[0].skip});
          if (q[0].forced) err_model = 1'b1;
          if (obf_ready) begin
            if (m_insn < 16'hFFFF) m_insn++;
            if (q[0].last && m_seq < 16'hFFFF) m_seq++;
            void'(q.pop_front());
            n_deliv++;
          end
        end
      end
      chk("seq_err", {31'h0, seq_err}, {31'h0, err_model});
      if (flush) q.delete();
      if (ref_valid && ref_ready) begin
        if (!obf_en) begin
          it.insn = ref_insn; it.last = 1'b1; it.skip = 1'b0; it.forced = 1'b0;
          q.push_back(it);
        end else begin
          int len;
          len = seq_len(ref_insn, len_override);
          for (int i = 0; i < MAX_SEQ; i++) begin
            it.insn   = ref_insn ^ {key_model, 20'h0, 4'(i)};
            it.skip   = 1'(i) ^ ref_insn[4];
            it.last   = (i == len - 1) || (i == MAX_SEQ - 1);
            it.forced = (i == MAX_SEQ - 1) && (len > MAX_SEQ);
            q.push_back(it);
            if (it.last) break;
          end
        end
      end
      if (key_we) key_model = key_i;
    end
  end

  task automatic do_accept(input logic [31:0] r, input logic en);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    ref_insn = r; obf_en = en; ref_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (ref_ready) ok = 1'b1;
      @(posedge clk);
    end
    #1 ref_valid = 1'b0;
    chk("accept_done", {31'h0, ok}, 32'h1);
  endtask

  task automatic wait_idle(input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !obf_valid && ref_ready) done = 1'b1;
    end
    chk(nm, {31'h0, done}, 32'h1);
  endtask

  logic [31:0] exp_a [3];
  int d0;
`ifdef OBF_SEQ_STATS_EN
  logic [15:0] s0, i0;
`endif

  initial begin
    rst = 1'b0; ref_valid = 1'b0; ref_insn = '0; obf_en = 1'b1; key_i = '0;
    key_we = 1'b0; flush = 1'b0; obf_ready = 1'b1;
    exp_a[0] = 32'hE0621800; exp_a[1] = 32'hE0621801; exp_a[2] = 32'hE0621802;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ref_ready", {31'h0, ref_ready}, 32'h0);
    chk("rst_obf_valid", {31'h0, obf_valid}, 32'h0);
    chk("rst_obf_insn", obf_insn, 32'h0);
    chk("rst_obf_last_skip", {30'h0, obf_last, obf_skip}, 32'h0);
    chk("rst_seq_err", {31'h0, seq_err}, 32'h0);
    chk("rst_gen", {gen_ppc, gen_key, 20'h0} | gen_ref, 32'h0);
`ifdef OBF_SEQ_STATS_EN
    chk("rst_stats", {stat_seq, stat_insn}, 32'h0);
`endif
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;

    // basic 3-step sequence, latency N+2
    len_override = 3;
    do_accept(32'hE0621800, 1'b1);
    @(negedge clk);
    chk("a_lat_valid", {31'h0, obf_valid}, 32'h0);
    chk("a_ppc0", {28'h0, gen_ppc}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("a_valid", {31'h0, obf_valid}, 32'h1);
      chk("a_insn", obf_insn, exp_a[k]);
      chk("a_last", {31'h0, obf_last}, (k == 2) ? 32'h1 : 32'h0);
      chk("a_ppc", {28'h0, gen_ppc}, (k == 2) ? 32'h0 : k + 1);
    end
    @(negedge clk);
    chk("a_drop", {31'h0, obf_valid}, 32'h0);
    chk("a_err", {31'h0, seq_err}, 32'h0);

    // backpressure mid-sequence
    len_override = 4;
    do_accept(32'h12345670, 1'b1);
    @(posedge clk); #1 obf_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("b_hold_insn", obf_insn, 32'h12345670);
      chk("b_hold_last", {31'h0, obf_last}, 32'h0);
      chk("b_hold_ppc", {28'h0, gen_ppc}, 32'h1);
    end
    @(posedge clk); #1 obf_ready = 1'b1;
    wait_idle("b_idle");

    // sequence cut at MAX_SEQ
    len_override = 9;
    d0 = n_deliv;
    do_accept(32'h00000A00, 1'b1);
    wait_idle("c_idle");
    chk("c_count", n_deliv - d0, 32'd8);
    chk("c_err", {31'h0, seq_err}, 32'h1);
    len_override = 2;
    do_accept(32'h00000B00, 1'b1);
    wait_idle("c2_idle");
    chk("c_err_sticky", {31'h0, seq_err}, 32'h1);

    // flush at 2nd output with simultaneous ref_valid
    len_override = 4;
    do_accept(32'hABCD0000, 1'b1);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    flush = 1'b1; ref_valid = 1'b1; ref_insn = 32'h11111111;
    @(negedge clk);
    chk("d_no_accept", {31'h0, ref_ready}, 32'h0);
    @(posedge clk); #1;
    flush = 1'b0; ref_valid = 1'b0;
    @(negedge clk);
    chk("d_valid_low", {31'h0, obf_valid}, 32'h0);
    chk("d_ppc0", {28'h0, gen_ppc}, 32'h0);
    do_accept(32'h22222220, 1'b1);
    @(negedge clk);
    chk("d_restart_ppc", {28'h0, gen_ppc}, 32'h0);
    @(negedge clk);
    chk("d_restart_insn", obf_insn, 32'h22222220);
    wait_idle("d_idle");

    // key staging
    @(posedge clk); #1 key_i = 8'h3C; key_we = 1'b1;
    @(posedge clk); #1 key_we = 1'b0;
    do_accept(32'h55550000, 1'b1);
    key_i = 8'hA5; key_we = 1'b1;
    @(negedge clk);
    chk("e_key_old0", {24'h0, gen_key}, 32'h3C);
    @(posedge clk); #1 key_we = 1'b0;
    @(negedge clk);
    chk("e_insn_old", obf_insn, 32'h69550000);
    chk("e_key_old1", {24'h0, gen_key}, 32'h3C);
    wait_idle("e_idle");
    chk("e_key_end", {24'h0, gen_key}, 32'h3C);
    do_accept(32'h55550000, 1'b1);
    @(negedge clk);
    chk("e_key_new", {24'h0, gen_key}, 32'hA5);
    @(negedge clk);
    chk("e_insn_new", obf_insn, 32'hF0550000);
    wait_idle("e2_idle");

    // bypass
`ifdef OBF_SEQ_STATS_EN
    s0 = stat_seq; i0 = stat_insn;
`endif
    do_accept(32'h9C210004, 1'b0);
    @(negedge clk);
    chk("f_lat_valid", {31'h0, obf_valid}, 32'h0);
    @(negedge clk);
    chk("f_valid", {31'h0, obf_valid}, 32'h1);
    chk("f_insn", obf_insn, 32'h9C210004);
    chk("f_last_skip", {30'h0, obf_last, obf_skip}, 32'h2);
    @(negedge clk);
    chk("f_drop", {31'h0, obf_valid}, 32'h0);
`ifdef OBF_SEQ_STATS_EN
    chk("f_stat_seq", {16'h0, stat_seq - s0}, 32'h1);
    chk("f_stat_insn", {16'h0, stat_insn - i0}, 32'h1);
`endif

    // randomized traffic
    len_override = 0;
    repeat (3000) begin
      @(posedge clk); #1;
      ref_valid = ($urandom_range(0, 3) != 0);
      ref_insn  = $urandom;
      obf_en    = ($urandom_range(0, 3) != 0);
      obf_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      key_we    = ($urandom_range(0, 7) == 0);
      key_i     = 8'($urandom);
    end
    @(posedge clk); #1;
    ref_valid = 1'b0; flush = 1'b0; key_we = 1'b0; obf_ready = 1'b1;
    wait_idle("rand_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
